// File: rtl/expr_ctrl.sv
// expr_ctrl: sequencing controller for an ASCII expression stream of the form
//   digit (op digit)* '='   with op in {'+','*'}
// Evaluates the expression with normal precedence ('*' binds tighter than '+')
// using a sum/term accumulator pair and a pending-multiply flag.
//
// Ports:
//   clk       system clock, rising edge
//   clr       synchronous active-high clear, priority over in_valid
//   in        ASCII character, sampled when in_valid=1
//   in_valid  character strobe
//   ok        accepted prefix is a complete valid expression
//   done      one-cycle pulse after '=' completes a valid expression
//   result    value of the last finished expression (mod 2^W)
//   err       sticky error flag, cleared only by clr
//   busy      expression partially entered
module expr_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [7:0]   in,
    input  logic         in_valid,
    output logic         ok,
    output logic         done,
    output logic [W-1:0] result,
    output logic         err,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_DIGIT,
        S_OP,
        S_ERR
    } state_t;

    state_t       r_state, w_state_nx;
    logic [W-1:0] r_sum, w_sum_nx;
    logic [W-1:0] r_term, w_term_nx;
    logic [W-1:0] r_result, w_result_nx;
    logic         r_mul_pend, w_mul_pend_nx;
    logic         r_ok, w_ok_nx;
    logic         r_done, w_done_nx;
    logic         r_err, w_err_nx;
    logic         r_busy, w_busy_nx;

    logic         w_is_digit;
    logic         w_is_plus;
    logic         w_is_mul;
    logic         w_is_eq;
    logic [7:0]   w_dig8;
    logic [W-1:0] w_d;

    assign w_is_digit = (in >= 8'h30) && (in <= 8'h39);
    assign w_is_plus  = (in == 8'h2B);
    assign w_is_mul   = (in == 8'h2A);
    assign w_is_eq    = (in == 8'h3D);
    assign w_dig8     = in - 8'h30;
    assign w_d        = W'(w_dig8);

    always_comb begin
        w_state_nx    = r_state;
        w_sum_nx      = r_sum;
        w_term_nx     = r_term;
        w_result_nx   = r_result;
        w_mul_pend_nx = r_mul_pend;
        w_ok_nx       = r_ok;
        w_done_nx     = 1'b0;
        w_err_nx      = r_err;
        w_busy_nx     = r_busy;

        if (in_valid) begin
            case (r_state)
                S_DIGIT: begin
                    if (w_is_digit) begin
                        // A pending '*' folds the digit into the running product.
                        w_term_nx     = r_mul_pend ? (r_term * w_d) : w_d;
                        w_mul_pend_nx = 1'b0;
                        w_state_nx    = S_OP;
                        w_ok_nx       = 1'b1;
                        w_busy_nx     = 1'b1;
                    end else begin
                        w_state_nx = S_ERR;
                        w_err_nx   = 1'b1;
                        w_ok_nx    = 1'b0;
                        w_busy_nx  = 1'b0;
                    end
                end
                S_OP: begin
                    if (w_is_plus) begin
                        w_sum_nx   = r_sum + r_term;
                        w_state_nx = S_DIGIT;
                        w_ok_nx    = 1'b0;
                    end else if (w_is_mul) begin
                        w_mul_pend_nx = 1'b1;
                        w_state_nx    = S_DIGIT;
                        w_ok_nx       = 1'b0;
                    end else if (w_is_eq) begin
                        w_result_nx   = r_sum + r_term;
                        w_done_nx     = 1'b1;
                        w_sum_nx      = '0;
                        w_term_nx     = '0;
                        w_mul_pend_nx = 1'b0;
                        w_state_nx    = S_DIGIT;
                        w_ok_nx       = 1'b0;
                        w_busy_nx     = 1'b0;
                    end else begin
                        w_state_nx = S_ERR;
                        w_err_nx   = 1'b1;
                        w_ok_nx    = 1'b0;
                        w_busy_nx  = 1'b0;
                    end
                end
                default: begin
                    w_state_nx = S_ERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= S_DIGIT;
            r_sum      <= '0;
            r_term     <= '0;
            r_result   <= '0;
            r_mul_pend <= 1'b0;
            r_ok       <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_sum      <= w_sum_nx;
            r_term     <= w_term_nx;
            r_result   <= w_result_nx;
            r_mul_pend <= w_mul_pend_nx;
            r_ok       <= w_ok_nx;
            r_done     <= w_done_nx;
            r_err      <= w_err_nx;
            r_busy     <= w_busy_nx;
        end
    end

    assign ok     = r_ok;
    assign done   = r_done;
    assign result = r_result;
    assign err    = r_err;
    assign busy   = r_busy;

endmodule

// File: tb/tb_expr_ctrl.sv
// Testbench for expr_ctrl: a W=16 and a W=4 instance share one character
// stream. The reference model keeps the current expression as a token list
// and evaluates it as a sum of products when '=' arrives.
module tb_expr_ctrl;

    logic        clk;
    logic        clr;
    logic [7:0]  in;
    logic        in_valid;

    logic        ok16, done16, err16, busy16;
    logic [15:0] result16;
    logic        ok4, done4, err4, busy4;
    logic [3:0]  result4;

    int tests = 0;
    int fails = 0;

    // reference model state
    byte unsigned expr_q[$];
    logic        m_ok, m_done, m_err, m_busy;
    logic [15:0] m_res16;
    logic [3:0]  m_res4;

    expr_ctrl #(.W(16)) u_dut16 (
        .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
        .ok(ok16), .done(done16), .result(result16), .err(err16), .busy(busy16)
    );

    expr_ctrl #(.W(4)) u_dut4 (
        .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
        .ok(ok4), .done(done4), .result(result4), .err(err4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_digit(byte unsigned c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // Sum of products over the token list, modulo 2^16.
    function automatic logic [15:0] eval_expr();
        longint unsigned sum;
        longint unsigned prod;
        sum  = 0;
        prod = expr_q[0] - 8'h30;
        for (int i = 1; i + 1 < expr_q.size(); i += 2) begin
            if (expr_q[i] == 8'h2A) begin
                prod = (prod * (expr_q[i+1] - 8'h30)) & 64'hFFFF;
            end else begin
                sum  = (sum + prod) & 64'hFFFF;
                prod = expr_q[i+1] - 8'h30;
            end
        end
        sum = (sum + prod) & 64'hFFFF;
        return sum[15:0];
    endfunction

    task automatic model_step(byte unsigned c, bit v, bit c_clr);
        logic [15:0] r;
        if (c_clr) begin
            expr_q.delete();
            m_ok = 0; m_done = 0; m_err = 0; m_busy = 0;
            m_res16 = 0; m_res4 = 0;
        end else begin
            m_done = 0;
            if (v && !m_err) begin
                if (expr_q.size() == 0 || !is_digit(expr_q[$])) begin
                    if (is_digit(c)) begin
                        expr_q.push_back(c);
                        m_ok = 1; m_busy = 1;
                    end else begin
                        m_err = 1; m_ok = 0; m_busy = 0;
                        expr_q.delete();
                    end
                end else begin
                    if (c == 8'h2B || c == 8'h2A) begin
                        expr_q.push_back(c);
                        m_ok = 0;
                    end else if (c == 8'h3D) begin
                        r = eval_expr();
                        m_res16 = r;
                        m_res4  = r[3:0];
                        m_done = 1; m_ok = 0; m_busy = 0;
                        expr_q.delete();
                    end else begin
                        m_err = 1; m_ok = 0; m_busy = 0;
                        expr_q.delete();
                    end
                end
            end
        end
    endtask

    task automatic check_all(string tag);
        tests++;
        assert (ok16 === m_ok) else begin
            fails++; $error("FAIL %s ok16 observed=%0b expected=%0b", tag, ok16, m_ok);
        end
        tests++;
        assert (done16 === m_done) else begin
            fails++; $error("FAIL %s done16 observed=%0b expected=%0b", tag, done16, m_done);
        end
        tests++;
        assert (err16 === m_err) else begin
            fails++; $error("FAIL %s err16 observed=%0b expected=%0b", tag, err16, m_err);
        end
        tests++;
        assert (busy16 === m_busy) else begin
            fails++; $error("FAIL %s busy16 observed=%0b expected=%0b", tag, busy16, m_busy);
        end
        tests++;
        assert (result16 === m_res16) else begin
            fails++; $error("FAIL %s result16 observed=%0d expected=%0d", tag, result16, m_res16);
        end
        tests++;
        assert (ok4 === m_ok && done4 === m_done && err4 === m_err && busy4 === m_busy) else begin
            fails++; $error("FAIL %s flags4 observed=%0b%0b%0b%0b expected=%0b%0b%0b%0b", tag,
                            ok4, done4, err4, busy4, m_ok, m_done, m_err, m_busy);
        end
        tests++;
        assert (result4 === m_res4) else begin
            fails++; $error("FAIL %s result4 observed=%0d expected=%0d", tag, result4, m_res4);
        end
    endtask

    // One clock cycle: drive, clock, update model, check 1 time unit later.
    task automatic step(byte unsigned c, bit v, bit c_clr, string tag);
        in       = c;
        in_valid = v;
        clr      = c_clr;
        @(posedge clk);
        model_step(c, v, c_clr);
        #1;
        check_all(tag);
    endtask

    task automatic send(string s, string tag);
        for (int i = 0; i < s.len(); i++) step(s[i], 1'b1, 1'b0, tag);
    endtask

    task automatic idle(int n, string tag);
        for (int i = 0; i < n; i++) step(8'h61, 1'b0, 1'b0, tag);
    endtask

    initial begin
        in = 8'h00; in_valid = 1'b0; clr = 1'b1;
        m_ok = 0; m_done = 0; m_err = 0; m_busy = 0; m_res16 = 0; m_res4 = 0;

        step(8'h00, 1'b0, 1'b1, "reset");
        send("1+2*3=", "prec_a");
        idle(1, "prec_a_post");
        tests++;
        assert (result16 === 16'd7) else begin
            fails++; $error("FAIL abs_1p2m3 observed=%0d expected=7", result16);
        end

        send("2*3+4*5=", "prec_b");
        tests++;
        assert (result16 === 16'd26) else begin
            fails++; $error("FAIL abs_26 observed=%0d expected=26", result16);
        end

        send("1+2", "mid_clr_pre");
        step(8'h33, 1'b1, 1'b1, "mid_clr");
        send("1+2*3=", "mid_clr_post");

        send("1++", "err_pp");
        send("3=", "err_sticky");
        idle(2, "err_idle");
        step(8'h00, 1'b0, 1'b1, "err_clr");

        send("9*9=", "w4_wrap");
        tests++;
        assert (result4 === 4'd1) else begin
            fails++; $error("FAIL abs_w4 observed=%0d expected=1", result4);
        end
        send("a", "illegal_first");
        step(8'h00, 1'b0, 1'b1, "clr2");

        send("3", "gap");
        idle(3, "gap_idle1");
        send("*", "gap");
        idle(1, "gap_idle2");
        send("3=", "gap_end");
        idle(2, "gap_post");
        tests++;
        assert (result16 === 16'd9) else begin
            fails++; $error("FAIL abs_gap observed=%0d expected=9", result16);
        end

        // back-to-back expressions with no gap after '='
        send("5*5=2+2=", "b2b");

        // randomized stream
        for (int n = 0; n < 1500; n++) begin
            int unsigned r;
            byte unsigned c;
            bit v;
            bit cc;
            r  = $urandom_range(0, 39);
            v  = ($urandom_range(0, 4) != 0);
            cc = (r == 39) || (m_err && ($urandom_range(0, 3) == 0));
            if (!m_busy || m_ok == 0) begin
                // expecting a digit most of the time
                if (r < 30) c = 8'h30 + byte'($urandom_range(0, 9));
                else if (r < 33) c = 8'h2B;
                else if (r < 35) c = 8'h3D;
                else c = 8'h2F + byte'($urandom_range(0, 1) * 11);
            end else begin
                if (r < 16) c = 8'h2A;
                else if (r < 28) c = 8'h2B;
                else if (r < 35) c = 8'h3D;
                else if (r < 37) c = 8'h30 + byte'($urandom_range(0, 9));
                else c = 8'h20;
            end
            step(c, v, cc, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
